col_encoder_rle: RTL

Parametrised column encoder: packs a stream of PIX_W-bit pixels into fixed-width typed packets. Runs of all-zero packets are replaced by a run-length packet, and a periodic timestamp packet is inserted from the global timer. Packets drain through an internal output FIFO with a valid/ready handshake, so the downstream link may stall without losing data until the FIFO is full. The block sits between one pixel column and the readout serialiser.

---
 rtl/col_encoder_rle.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/col_encoder_rle.sv
// col_encoder_rle
//   Packs a stream of PIX_W-bit pixels into PKT_W-bit typed packets
//   ({type[1:0], payload[PL_W-1:0]}). Runs of all-zero DATA packets collapse
//   into one ZRUN packet holding the run length. A periodic ALARM packet
//   carries a slice of the global timer. Packets leave through a show-ahead
//   FIFO with a valid/ready handshake.
//
// Ports
//   clk         clock
//   rst_n       asynchronous active-low reset
//   pixel_in    pixel value, sampled when data_valid=1
//   data_valid  pixel strobe (no input backpressure)
//   tik_tok     global timer
//   out_data    FIFO head packet (0 while empty)
//   out_valid   FIFO non-empty
//   out_ready   consumer accepts out_data when out_valid & out_ready
//   fifo_level  FIFO occupancy
//   drop_cnt    saturating count of packets lost to a full FIFO
module col_encoder_rle #(
  parameter int PIX_W      = 3,
  parameter int N_PIX      = 5,
  parameter int TS_W       = 32,
  parameter int ALARM_LOG2 = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int ZRUN_EN    = 1,
  localparam int PL_W      = PIX_W * N_PIX,
  localparam int PKT_W     = PL_W + 2,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] pixel_in,
  input  logic             data_valid,
  input  logic [TS_W-1:0]  tik_tok,
  output logic [PKT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LVL_W-1:0] fifo_level,
  output logic [15:0]      drop_cnt
);

  localparam int ACC_W  = PL_W - PIX_W;
  localparam int SLOT_W = $clog2(N_PIX);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  localparam logic [1:0] T_DATA  = 2'b00;
  localparam logic [1:0] T_ZRUN  = 2'b10;
  localparam logic [1:0] T_ALARM = 2'b11;

  typedef enum logic {ST_RUN = 1'b0, ST_SUPPRESS = 1'b1} state_t;

  // Accumulator only holds the first N_PIX-1 pixels; the last pixel is
  // taken straight from the input when the packet completes.
  logic [ACC_W-1:0]  r_acc;
  logic [SLOT_W-1:0] r_slot;
  state_t            r_state;
  logic [PL_W-1:0]   r_zrun_cnt;

  logic [PKT_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic [15:0]       r_drop_cnt;

  logic              w_pkt_done;
  logic [PL_W-1:0]   w_pkt_word;
  logic              w_pkt_zero;
  logic              w_alarm;
  logic [PL_W-1:0]   w_cnt_inc;
  state_t            w_state_next;
  logic [PL_W-1:0]   w_cnt_next;

  // Write candidates in fixed order: 0 = ZRUN, 1 = DATA, 2 = ALARM
  logic [2:0]        w_wr_en;
  logic [PKT_W-1:0]  w_wr_data [3];
  logic [2:0]        w_wr_acc;
  logic [PTR_W-1:0]  w_wr_idx [3];
  logic [LVL_W-1:0]  w_space;
  logic [LVL_W-1:0]  w_n_acc;
  logic [1:0]        w_n_drop;
  logic              w_pop;
  logic [16:0]       w_drop_sum;
  logic              w_unused_ts;

  assign w_pkt_done = data_valid && (r_slot == SLOT_W'(N_PIX - 1));
  assign w_pkt_word = {r_acc, pixel_in};
  assign w_pkt_zero = (w_pkt_word == '0);
  assign w_alarm    = &tik_tok[ALARM_LOG2-1:0];
  assign w_cnt_inc  = r_zrun_cnt + 1'b1;
  assign w_unused_ts = &{1'b0, tik_tok};

  // Pixel accumulator and slot counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_slot <= '0;
    end else if (data_valid) begin
      r_acc  <= w_pkt_word[ACC_W-1:0];
      r_slot <= w_pkt_done ? '0 : r_slot + 1'b1;
    end
  end

  // Zero-run FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_zrun_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_zrun_cnt <= w_cnt_next;
    end
  end

  // Zero-run FSM next state and packet write requests
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_zrun_cnt;
    w_wr_en      = 3'b000;
    w_wr_data[0] = {T_ZRUN, r_zrun_cnt};
    w_wr_data[1] = {T_DATA, w_pkt_word};
    w_wr_data[2] = {T_ALARM, tik_tok[ALARM_LOG2 +: PL_W]};

    if (w_pkt_done) begin
      if ((ZRUN_EN != 0) && w_pkt_zero) begin
        if (w_cnt_inc == '1) begin
          // Counter saturates: flush the full run and start over
          w_wr_en[0]   = 1'b1;
          w_wr_data[0] = {T_ZRUN, w_cnt_inc};
          w_cnt_next   = '0;
          w_state_next = ST_RUN;
        end else begin
          w_cnt_next   = w_cnt_inc;
          w_state_next = ST_SUPPRESS;
        end
      end else begin
        w_wr_en[0]   = (r_state == ST_SUPPRESS);
        w_wr_en[1]   = 1'b1;
        w_cnt_next   = '0;
        w_state_next = ST_RUN;
      end
    end

    if (w_alarm) begin
      w_wr_en[2] = 1'b1;
      // A pending run (including one extended this cycle) is closed
      // before the ALARM so the consumer never sees a run span an alarm.
      if (!w_wr_en[0] && (w_state_next == ST_SUPPRESS)) begin
        w_wr_en[0]   = 1'b1;
        w_wr_data[0] = {T_ZRUN, w_cnt_next};
      end
      w_cnt_next   = '0;
      w_state_next = ST_RUN;
    end
  end

  // Slot allocation: space is taken from the start-of-cycle level, so a
  // pop in the same cycle never makes room for this cycle's writes.
  always_comb begin
    w_space  = LVL_W'(FIFO_DEPTH) - r_level;
    w_n_acc  = '0;
    w_n_drop = '0;
    for (int i = 0; i < 3; i++) begin
      w_wr_acc[i] = 1'b0;
      w_wr_idx[i] = r_wr_ptr + w_n_acc[PTR_W-1:0];
      if (w_wr_en[i]) begin
        if (w_n_acc < w_space) begin
          w_wr_acc[i] = 1'b1;
          w_n_acc     = w_n_acc + 1'b1;
        end else begin
          w_n_drop = w_n_drop + 1'b1;
        end
      end
    end
  end

  assign w_pop      = out_valid && out_ready;
  assign w_drop_sum = {1'b0, r_drop_cnt} + {15'b0, w_n_drop};

  // Output FIFO storage, pointers, level and drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_drop_cnt <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_wr_acc[i]) begin
          r_mem[w_wr_idx[i]] <= w_wr_data[i];
        end
      end
      r_wr_ptr   <= r_wr_ptr + w_n_acc[PTR_W-1:0];
      r_rd_ptr   <= r_rd_ptr + PTR_W'(w_pop);
      r_level    <= r_level - LVL_W'(w_pop) + w_n_acc;
      r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  // Show-ahead head: only moves on a pop or on empty -> non-empty
  assign out_valid  = (r_level != '0);
  assign out_data   = out_valid ? r_mem[r_rd_ptr] : '0;
  assign fifo_level = r_level;
  assign drop_cnt   = r_drop_cnt;

endmodule
